// File: rtl/motor_move_if.sv
// Command, encoder and drive signals between the host/encoder side (master) and the
// move sequencer (slave). state_dbg mirrors the sequencer FSM state for observation.
interface motor_move_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_home;
   logic [8:0]  cmd_target;
   logic        cmd_abort;
   logic        fault_clr;
   logic [31:0] position;
   logic [31:0] rpm;
   logic        motor_dir;
   logic [15:0] duty;
   logic        position_rst;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  fault_code;
   logic [2:0]  state_dbg;

   // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; cmd_ready is
   // high only while the sequencer is IDLE and out of reset, and nothing is queued otherwise.
   modport master (
      output cmd_valid, cmd_home, cmd_target, cmd_abort, fault_clr, position, rpm,
      input  cmd_ready, motor_dir, duty, position_rst, busy, done, fault, fault_code, state_dbg
   );

   modport slave (
      input  cmd_valid, cmd_home, cmd_target, cmd_abort, fault_clr, position, rpm,
      output cmd_ready, motor_dir, duty, position_rst, busy, done, fault, fault_code, state_dbg
   );
endinterface

// File: rtl/motor_move_ctrl.sv
// Closed-loop absolute-angle move sequencer: shortest-direction moves with trapezoidal
// duty ramping, encoder homing, stall detection and abort.
module motor_move_ctrl #(
   parameter logic [15:0] PWM_MAX     = 16'd1000,
   parameter logic [15:0] MIN_DUTY    = 16'd150,
   parameter logic [15:0] RAMP_STEP   = 16'd10,
   parameter logic [31:0] RAMP_DIV    = 32'd100_000,
   parameter logic [8:0]  DECEL_DIST  = 9'd20,
   parameter logic [31:0] STALL_TICKS = 32'd500
) (
   input  logic        clk,
   input  logic        rst,
   motor_move_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HOME   = 3'd1,
      ACCEL  = 3'd2,
      CRUISE = 3'd3,
      DECEL  = 3'd4,
      FAULT  = 3'd5
   } state_t;

   state_t      state, state_nx;
   logic [15:0] duty_q, duty_nx;
   logic        dir_q, dir_nx;
   logic        prst_q, prst_nx;
   logic        done_q, done_nx;
   logic [1:0]  fcode_q, fcode_nx;
   logic [8:0]  target_q, target_nx;
   logic [31:0] presc_q, presc_nx;
   logic [31:0] stall_q, stall_nx;

   logic [8:0]  pos9, fwd, rem;
   logic        tick, arrived;
   logic [16:0] duty_up;

   // Distance stepping forward from 'from' to 'to' on a 360-degree circle; when to < from the
   // 9-bit wrap of to + 360 - from still lands exactly in 1..359.
   function automatic logic [8:0] fwd_dist(input logic [8:0] from, input logic [8:0] to);
      return (to >= from) ? (to - from) : (to + 9'd360 - from);
   endfunction

   assign pos9    = bus.position[8:0];
   assign fwd     = fwd_dist(pos9, bus.cmd_target);
   assign rem     = dir_q ? fwd_dist(pos9, target_q) : fwd_dist(target_q, pos9);
   assign tick    = (presc_q == RAMP_DIV - 32'd1);
   assign arrived = (bus.position == {23'd0, target_q});
   assign duty_up = {1'b0, duty_q} + {1'b0, RAMP_STEP};

   always_comb begin
      state_nx  = state;
      duty_nx   = duty_q;
      dir_nx    = dir_q;
      prst_nx   = 1'b0;
      done_nx   = 1'b0;
      fcode_nx  = fcode_q;
      target_nx = target_q;
      presc_nx  = presc_q;
      stall_nx  = stall_q;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_home) begin
                  state_nx = HOME;
                  prst_nx  = 1'b1;
               end else if (bus.cmd_target > 9'd359) begin
                  state_nx = FAULT;
                  fcode_nx = 2'b10;
                  duty_nx  = 16'd0;
               end else if ({23'd0, bus.cmd_target} == bus.position) begin
                  done_nx = 1'b1;
               end else begin
                  target_nx = bus.cmd_target;
                  dir_nx    = (fwd <= 9'd180);
                  duty_nx   = MIN_DUTY;
                  presc_nx  = 32'd0;
                  stall_nx  = 32'd0;
                  state_nx  = ACCEL;
               end
            end
         end
         // First HOME cycle carries the encoder reset pulse, the second one the done pulse.
         HOME: begin
            if (prst_q) done_nx  = 1'b1;
            else        state_nx = IDLE;
         end
         ACCEL, CRUISE, DECEL: begin
            presc_nx = tick ? 32'd0 : presc_q + 32'd1;
            if (bus.cmd_abort) begin
               duty_nx  = 16'd0;
               state_nx = IDLE;
            end else if (arrived) begin
               duty_nx  = 16'd0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               if (tick) stall_nx = (bus.rpm == 32'd0) ? stall_q + 32'd1 : 32'd0;
               if (tick && bus.rpm == 32'd0 && stall_q + 32'd1 == STALL_TICKS) begin
                  duty_nx  = 16'd0;
                  fcode_nx = 2'b01;
                  state_nx = FAULT;
               end else if (state != DECEL && rem <= DECEL_DIST) begin
                  state_nx = DECEL;
               end else if (tick && state == ACCEL) begin
                  if (duty_up >= {1'b0, PWM_MAX}) begin
                     duty_nx  = PWM_MAX;
                     state_nx = CRUISE;
                  end else begin
                     duty_nx = duty_up[15:0];
                  end
               end else if (tick && state == DECEL) begin
                  if ({1'b0, duty_q} <= {1'b0, MIN_DUTY} + {1'b0, RAMP_STEP}) duty_nx = MIN_DUTY;
                  else                                                       duty_nx = duty_q - RAMP_STEP;
               end
            end
         end
         FAULT: begin
            duty_nx = 16'd0;
            if (bus.fault_clr) begin
               fcode_nx = 2'b00;
               state_nx = IDLE;
            end
         end
         default: begin
            duty_nx  = 16'd0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         duty_q   <= 16'd0;
         dir_q    <= 1'b0;
         prst_q   <= 1'b0;
         done_q   <= 1'b0;
         fcode_q  <= 2'b00;
         target_q <= 9'd0;
         presc_q  <= 32'd0;
         stall_q  <= 32'd0;
      end else begin
         state    <= state_nx;
         duty_q   <= duty_nx;
         dir_q    <= dir_nx;
         prst_q   <= prst_nx;
         done_q   <= done_nx;
         fcode_q  <= fcode_nx;
         target_q <= target_nx;
         presc_q  <= presc_nx;
         stall_q  <= stall_nx;
      end
   end

   assign bus.cmd_ready    = (state == IDLE) && !rst;
   assign bus.busy         = (state != IDLE);
   assign bus.fault        = (state == FAULT);
   assign bus.duty         = duty_q;
   assign bus.motor_dir    = dir_q;
   assign bus.position_rst = prst_q;
   assign bus.done         = done_q;
   assign bus.fault_code   = fcode_q;
   assign bus.state_dbg    = state;
endmodule

// File: tb/tb_motor_move_ctrl.sv
// Directed bench for motor_move_ctrl with RAMP_DIV=4 and STALL_TICKS=8.
module tb_motor_move_ctrl;
   localparam logic [31:0] S_IDLE   = 32'd0;
   localparam logic [31:0] S_HOME   = 32'd1;
   localparam logic [31:0] S_ACCEL  = 32'd2;
   localparam logic [31:0] S_CRUISE = 32'd3;
   localparam logic [31:0] S_DECEL  = 32'd4;
   localparam logic [31:0] S_FAULT  = 32'd5;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] exp_q[$];

   motor_move_if bus();

   motor_move_ctrl #(.RAMP_DIV(32'd4), .STALL_TICKS(32'd8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Checker
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_duty_exp(input string tag);
      if (exp_q.size() == 0) check_eq({tag, "_noexp"}, 32'd1, 32'd0);
      else                   check_eq(tag, {16'd0, bus.duty}, exp_q.pop_front());
   endtask

   // Drivers: inputs change 1 time unit after the active edge, outputs are sampled there too.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic home, input logic [8:0] tgt);
      bus.cmd_home   = home;
      bus.cmd_target = tgt;
      bus.cmd_valid  = 1'b1;
      run(1);
      bus.cmd_valid  = 1'b0;
      bus.cmd_home   = 1'b0;
   endtask

   task automatic abort_move();
      bus.cmd_abort = 1'b1;
      run(1);
      bus.cmd_abort = 1'b0;
   endtask

   task automatic check_dir_case(input string tag, input logic [31:0] pos,
                                 input logic [8:0] tgt, input logic exp_dir);
      bus.position = pos;
      issue(1'b0, tgt);
      check_eq({tag, "_dir"}, {31'd0, bus.motor_dir}, {31'd0, exp_dir});
      check_eq({tag, "_state"}, {29'd0, bus.state_dbg}, S_ACCEL);
      abort_move();
      check_eq({tag, "_abort_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int cnt;
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_home   = 1'b0;
      bus.cmd_target = 9'd0;
      bus.cmd_abort  = 1'b0;
      bus.fault_clr  = 1'b0;
      bus.position   = 32'd0;
      bus.rpm        = 32'd100;

      // Reset state
      run(2);
      check_eq("rst_duty", {16'd0, bus.duty}, 32'd0);
      check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("rst_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check_eq("rst_state", {29'd0, bus.state_dbg}, S_IDLE);
      check_eq("rst_fault_code", {30'd0, bus.fault_code}, 32'd0);
      check_eq("rst_prst", {31'd0, bus.position_rst}, 32'd0);
      check_eq("rst_done", {31'd0, bus.done}, 32'd0);

      // Home
      bus.position = 32'd100;
      issue(1'b1, 9'd0);
      check_eq("home_prst1", {31'd0, bus.position_rst}, 32'd1);
      check_eq("home_done0", {31'd0, bus.done}, 32'd0);
      check_eq("home_busy1", {31'd0, bus.busy}, 32'd1);
      run(1);
      check_eq("home_prst2", {31'd0, bus.position_rst}, 32'd0);
      check_eq("home_done2", {31'd0, bus.done}, 32'd1);
      check_eq("home_busy2", {31'd0, bus.busy}, 32'd1);
      run(1);
      check_eq("home_done3", {31'd0, bus.done}, 32'd0);
      check_eq("home_busy3", {31'd0, bus.busy}, 32'd0);
      check_eq("home_ready3", {31'd0, bus.cmd_ready}, 32'd1);

      // Forward move 10 -> 50 with hand-computed duty checkpoints
      exp_q.push_back(32'd150); exp_q.push_back(32'd150); exp_q.push_back(32'd160);
      exp_q.push_back(32'd170); exp_q.push_back(32'd170); exp_q.push_back(32'd160);
      exp_q.push_back(32'd150); exp_q.push_back(32'd150); exp_q.push_back(32'd0);
      bus.position = 32'd10;
      issue(1'b0, 9'd50);
      check_eq("fwd_dir", {31'd0, bus.motor_dir}, 32'd1);
      check_duty_exp("fwd_duty_e1");
      run(3);  check_duty_exp("fwd_duty_e4");
      run(1);  check_duty_exp("fwd_duty_e5");
      run(4);  check_duty_exp("fwd_duty_e9");
      check_eq("fwd_state_accel", {29'd0, bus.state_dbg}, S_ACCEL);
      bus.position = 32'd30;
      run(1);  check_duty_exp("fwd_duty_decel_entry");
      check_eq("fwd_state_decel", {29'd0, bus.state_dbg}, S_DECEL);
      run(3);  check_duty_exp("fwd_duty_e13");
      run(4);  check_duty_exp("fwd_duty_e17");
      run(4);  check_duty_exp("fwd_duty_floor");
      check_eq("fwd_dir_held", {31'd0, bus.motor_dir}, 32'd1);
      check_eq("fwd_done_early", {31'd0, bus.done}, 32'd0);
      bus.position = 32'd50;
      run(1);  check_duty_exp("fwd_duty_arrive");
      check_eq("fwd_done", {31'd0, bus.done}, 32'd1);
      check_eq("fwd_busy_arrive", {31'd0, bus.busy}, 32'd0);
      run(1);
      check_eq("fwd_done_clear", {31'd0, bus.done}, 32'd0);

      // Direction selection across the wrap and the 180-degree tie
      check_dir_case("wrap_350_5", 32'd350, 9'd5, 1'b1);
      check_dir_case("tie_0_180", 32'd0, 9'd180, 1'b1);
      check_dir_case("rev_0_181", 32'd0, 9'd181, 1'b0);

      // Move to current position: done only
      bus.position = 32'd77;
      issue(1'b0, 9'd77);
      check_eq("same_done", {31'd0, bus.done}, 32'd1);
      check_eq("same_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("same_duty", {16'd0, bus.duty}, 32'd0);

      // Ramp to CRUISE (85 ticks of 4 clocks), ignore a command, abort
      bus.position = 32'd0;
      issue(1'b0, 9'd90);
      cnt = 0;
      while (bus.state_dbg != S_CRUISE[2:0] && cnt < 500) begin
         run(1);
         cnt++;
      end
      check_eq("cruise_clks", cnt, 32'd340);
      check_eq("cruise_duty", {16'd0, bus.duty}, 32'd1000);
      issue(1'b1, 9'd10);
      check_eq("busy_cmd_ignored_prst", {31'd0, bus.position_rst}, 32'd0);
      check_eq("busy_cmd_ignored_state", {29'd0, bus.state_dbg}, S_CRUISE);
      run(5);
      check_eq("cruise_duty_hold", {16'd0, bus.duty}, 32'd1000);
      abort_move();
      check_eq("abort_duty", {16'd0, bus.duty}, 32'd0);
      check_eq("abort_done", {31'd0, bus.done}, 32'd0);
      check_eq("abort_state", {29'd0, bus.state_dbg}, S_IDLE);

      // Stall with rpm held at zero
      bus.rpm = 32'd0;
      issue(1'b0, 9'd90);
      run(31);
      check_eq("stall_early", {31'd0, bus.fault}, 32'd0);
      run(1);
      check_eq("stall_fault", {31'd0, bus.fault}, 32'd1);
      check_eq("stall_code", {30'd0, bus.fault_code}, 32'd1);
      check_eq("stall_duty", {16'd0, bus.duty}, 32'd0);
      check_eq("stall_ready", {31'd0, bus.cmd_ready}, 32'd0);
      bus.fault_clr = 1'b1;
      run(1);
      bus.fault_clr = 1'b0;
      check_eq("clr_fault", {31'd0, bus.fault}, 32'd0);
      check_eq("clr_code", {30'd0, bus.fault_code}, 32'd0);
      check_eq("clr_ready", {31'd0, bus.cmd_ready}, 32'd1);
      bus.rpm = 32'd100;

      // Bad target; abort has no effect in FAULT
      issue(1'b0, 9'd400);
      check_eq("bad_fault", {31'd0, bus.fault}, 32'd1);
      check_eq("bad_code", {30'd0, bus.fault_code}, 32'd2);
      check_eq("bad_duty", {16'd0, bus.duty}, 32'd0);
      abort_move();
      check_eq("bad_abort_ignored", {29'd0, bus.state_dbg}, S_FAULT);
      bus.fault_clr = 1'b1;
      run(1);
      bus.fault_clr = 1'b0;
      check_eq("bad_clr_state", {29'd0, bus.state_dbg}, S_IDLE);

      // Asynchronous reset mid-ACCEL
      bus.position = 32'd0;
      issue(1'b0, 9'd90);
      run(4);
      check_eq("arst_pre_duty", {16'd0, bus.duty}, 32'd160);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_duty", {16'd0, bus.duty}, 32'd0);
      check_eq("arst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("arst_state", {29'd0, bus.state_dbg}, S_IDLE);
      rst = 1'b0;
      run(1);
      check_eq("arst_ready", {31'd0, bus.cmd_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/motor_move_ctrl.md
Name: motor_move_ctrl

Overview:
Closed-loop move sequencer for a single brushed motor with a quadrature encoder. It accepts absolute-angle move commands (0..359 deg) and a home command. It drives motor direction and PWM duty with trapezoidal ramping, uses the encoder's live position and RPM outputs, and pulses the encoder position reset for homing. It sits between the bus-facing register block and the encoder/PWM pair.

Parameters:
PWM_MAX, 16'd1000, full-scale duty value (cruise duty)
MIN_DUTY, 16'd150, start/creep duty; DECEL never ramps below this
RAMP_STEP, 16'd10, duty change per ramp tick
RAMP_DIV, 32'd100_000, clocks per ramp tick (1 ms at 100 MHz)
DECEL_DIST, 9'd20, remaining degrees at or below which DECEL begins
STALL_TICKS, 32'd500, consecutive ramp ticks with rpm==0 while moving -> stall fault

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_home  in  1  sampled with the command: 1 = home, 0 = move
cmd_target  in  9  target angle for move commands
cmd_abort  in  1  stop immediately
fault_clr  in  1  clears FAULT
position  in  32  encoder angle, 0..359
rpm  in  32  encoder speed
motor_dir  out  1  1 = position increments
duty  out  16  PWM duty
position_rst  out  1  one-cycle pulse to the encoder
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on move arrival or home completion
fault  out  1  high in FAULT
fault_code  out  2  00 none, 01 stall, 10 bad target

Behaviour:
- Reset (async): state IDLE; duty=0, motor_dir=0, position_rst=0, done=0, fault=0, fault_code=00, all counters 0. cmd_ready=1 once rst deasserts.
- States: IDLE, HOME, ACCEL, CRUISE, DECEL, FAULT. All outputs are registered.
- IDLE, accept with cmd_home=1: position_rst=1 for exactly one cycle (state HOME). Next cycle: done=1, return to IDLE.
- IDLE, accept move with cmd_target>359: enter FAULT with fault_code=10 and duty=0.
- IDLE, accept move with cmd_target==position: done pulses the next cycle, stay IDLE, duty stays 0.
- IDLE, accept other moves: latch target and compute fwd=(target-position) mod 360. If fwd<=180: motor_dir=1, else motor_dir=0 (a tie of 180 goes forward). motor_dir is then held for the whole move. Set duty=MIN_DUTY, clear the ramp prescaler and stall counter, enter ACCEL.
- Remaining distance is recomputed every cycle from live position along the latched direction, in the range 0..359, using 9-bit modular arithmetic.
- Ramp tick: prescaler counts 0..RAMP_DIV-1 while in ACCEL/CRUISE/DECEL; a tick fires on the terminal count.
- Per-cycle priority in moving states: abort > arrival > stall > decel entry > ramp.
  - abort: duty=0, go to IDLE, no done pulse. abort is ignored in IDLE and FAULT.
  - arrival (position==target): duty=0, done=1 for one cycle, go to IDLE.
  - stall: on each tick, if rpm==0 the stall counter increments, else it clears. When it reaches STALL_TICKS: duty=0, fault_code=01, go to FAULT.
  - decel entry: remaining<=DECEL_DIST in ACCEL or CRUISE -> go to DECEL (duty unchanged that cycle).
  - ACCEL tick: duty=min(duty+RAMP_STEP, PWM_MAX). On reaching PWM_MAX, go to CRUISE.
  - DECEL tick: duty=max(duty-RAMP_STEP, MIN_DUTY). Stay in DECEL until arrival.
- Duty arithmetic uses 17-bit intermediates; no wrap.
- FAULT: duty=0, cmd_ready=0. fault_clr clears fault and fault_code and returns to IDLE. fault_clr in other states has no effect.
- cmd_valid outside IDLE is ignored (not queued).

Test Plan:
- Use RAMP_DIV=4, STALL_TICKS=8 in sim.
- Home: position=100, cmd_valid+cmd_home -> position_rst high 1 cycle, done 1 cycle later, busy high 2 cycles.
- Forward move: position=10, target=50 -> motor_dir=1. duty 150 and rises by 10 every 4 clks. DECEL entered at position=30. duty floors at 150. At position=50: duty=0, done=1.
- Wrap/tie: position=350, target=5 -> motor_dir=1 (fwd=15). position=0, target=180 -> motor_dir=1. position=0, target=181 -> motor_dir=0.
- Stall: move with rpm held 0 -> after 8 ticks (32 clks) fault=1, fault_code=01, duty=0. fault_clr -> IDLE, cmd_ready=1.
- Abort and bad target: cmd_abort mid-CRUISE -> duty=0 next cycle, no done. Target=400 -> fault_code=10.
- Async reset mid-ACCEL -> duty=0 and busy=0 immediately, without waiting for a clock edge.
